spi_stream_master: RTL and testbench
====================================

SPI_STREAM_MASTER -- requirements
Module: spi_stream_master

Interface
REQ-001 SHALL have parameter WIDTH_SPI_WORD, default 8, bits per SPI word (legal range 1..32).
REQ-002 SHALL have parameter CLK_DIV, default 7, the clk cycles per spi_clk half-period (legal range 1..255).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port tx_data, input, WIDTH_SPI_WORD bits: the word to serialise.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_last, input, 1 bit: chip_select_n is released after this word; 0 means stream mode and CS stays low.
REQ-010 SHALL have port tx_ready, output, 1 bit: the word is accepted in a cycle where tx_valid and tx_ready are both high.
REQ-011 SHALL have port rx_data, output, WIDTH_SPI_WORD bits: the word captured from MISO.
REQ-012 SHALL have port rx_valid, output, 1 bit: a one-cycle pulse marking a new rx_data.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port spi_clk, output, 1 bit: SPI clock, idle low.
REQ-015 SHALL have port MOSI, output, 1 bit: serial data out.
REQ-016 SHALL have port MISO, input, 1 bit: serial data in.
REQ-017 SHALL have port chip_select_n, output, 1 bit: active-low chip select.

Function
REQ-018 SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI, STREAM_WAIT, CS_HOLD and CS_IDLE.
REQ-019 SHALL register tx_data and tx_last on accept; tx_data SHALL NOT be sampled after the handshake cycle.
REQ-020 SHALL, on the cycle after an accept from IDLE, drive chip_select_n=0 and MOSI=first bit, then enter SHIFT_LO.
REQ-021 SHALL hold spi_clk low for CLK_DIV cycles in SHIFT_LO and high for CLK_DIV cycles in SHIFT_HI (SPI mode 0).
REQ-022 SHALL change MOSI only on entry to SHIFT_LO, so MOSI is stable for the whole SHIFT_HI phase.
REQ-023 SHALL take exactly 2*CLK_DIV*WIDTH_SPI_WORD cycles per word, from the first SHIFT_LO cycle to the last SHIFT_HI cycle.
REQ-024 SHALL, in the last SHIFT_HI cycle of a word with latched tx_last=0, assert tx_ready.
REQ-025 SHALL, if a stream word is accepted in that last SHIFT_HI cycle, start the next word's SHIFT_LO on the next cycle with no spi_clk gap.
REQ-026 SHALL, if no stream word is accepted in that cycle, enter STREAM_WAIT: spi_clk=0, chip_select_n=0, MOSI held, tx_ready=1.
REQ-027 SHALL, on an accept in STREAM_WAIT, start SHIFT_LO on the next cycle.
REQ-028 SHALL, after the last SHIFT_HI of a word with latched tx_last=1, spend CLK_DIV cycles in CS_HOLD (spi_clk=0, CS low), then drive chip_select_n=1.
REQ-029 SHALL, after CS_HOLD, spend CLK_DIV cycles in CS_IDLE (CS high, tx_ready=0) before returning to IDLE.
REQ-030 SHALL hold tx_ready=1 in IDLE and STREAM_WAIT and 0 in all other cycles except the case in REQ-024.
REQ-031 SHALL ignore tx_valid while tx_ready=0; no word is queued or dropped.
REQ-032 SHALL count bits with a counter of width ceil(log2(WIDTH_SPI_WORD+1)) and phase cycles with an 8-bit counter; both SHALL wrap to 0 at each phase or word boundary.
REQ-033 SHALL, when CLK_DIV=1, toggle spi_clk every cycle with identical state ordering.

Reset
REQ-034 SHALL, while reset is high, force chip_select_n=1, spi_clk=0, MOSI=0, tx_ready=0, busy=0, rx_valid=0 and rx_data=0, with the state at IDLE.
REQ-035 SHALL, when reset is asserted mid-word or in STREAM_WAIT, abort the transfer without any CS_HOLD and drop the partial word, taking reset values on the next clk edge.
REQ-036 SHALL assert tx_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-037 SHALL, when SPI_STREAM_MISO_CAPTURE_EN is defined, sample MISO in the first cycle of each SHIFT_HI into a shift register in the same bit order as MOSI.
REQ-038 SHALL, with SPI_STREAM_MISO_CAPTURE_EN defined, update rx_data and pulse rx_valid for one cycle on the cycle after each word's last SHIFT_HI; rx_data holds until the next word.
REQ-039 SHALL, when SPI_STREAM_MISO_CAPTURE_EN is undefined, tie rx_data=0 and rx_valid=0 and synthesise no capture register.

Verification
REQ-040 SHALL cover: W=8, CLK_DIV=2, 0xA5 sent with tx_last=1 -> MOSI 1,0,1,0,0,1,0,1 at 8 rising spi_clk edges, CS low for 34 cycles, tx_ready back after 2 more.
REQ-041 SHALL cover: stream 0x3C (tx_last=0) then 0xC3 (tx_last=1) with tx_valid held -> 16 contiguous spi_clk pulses, CS low throughout, one CS rise.
REQ-042 SHALL cover: stream 0x01 (tx_last=0) with tx_valid dropped for 10 cycles -> STREAM_WAIT with CS low and spi_clk low, then 0x80 resumes one cycle after accept.
REQ-043 SHALL cover: reset asserted at bit 4 of 0xFF -> next cycle chip_select_n=1, spi_clk=0, MOSI=0, tx_ready=1 after release, no rx_valid.
REQ-044 SHALL cover: capture macro defined, MISO driven 0x5A in loopback, MSB_FIRST=0 -> rx_data=0x5A with a single rx_valid pulse.
REQ-045 SHALL cover: CLK_DIV=1, W=16, 0xBEEF -> 32 cycles of spi_clk toggling every cycle and correct MOSI bit order.

Source files
------------

// File: rtl/spi_stream_master.sv
// SPI mode-0 stream master: serialises tx words, holds CS across stream words.
// Optional MISO capture is enabled by defining SPI_STREAM_MISO_CAPTURE_EN.
module spi_stream_master #(
    parameter int WIDTH_SPI_WORD = 8,
    parameter int CLK_DIV        = 7,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH_SPI_WORD-1:0] tx_data,
    input  logic                      tx_valid,
    input  logic                      tx_last,
    output logic                      tx_ready,
    output logic [WIDTH_SPI_WORD-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      busy,
    output logic                      spi_clk,
    output logic                      MOSI,
    input  logic                      MISO,
    output logic                      chip_select_n
);

    localparam int W  = WIDTH_SPI_WORD;
    localparam int BW = $clog2(W + 1);
    localparam logic [7:0]    DIV_END = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END = BW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        STREAM_WAIT,
        CS_HOLD,
        CS_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          mosi_q, mosi_d;
    logic          last_q, last_d;

    logic phase_end;
    logic word_end;
    logic ready;
    logic accept;

    assign phase_end = (cnt_q == DIV_END);
    assign word_end  = (state_q == SHIFT_HI) && phase_end && (bit_q == BIT_END);
    assign ready     = !reset && ((state_q == IDLE) || (state_q == STREAM_WAIT) ||
                                  (word_end && !last_q));
    assign accept    = tx_valid && ready;

    // Next-state logic: phase/bit counting and MOSI update on SHIFT_LO entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        mosi_d  = mosi_q;
        last_d  = last_q;
        if (accept) begin
            last_d = tx_last;
            if (MSB_FIRST) begin
                mosi_d = tx_data[W-1];
                sh_d   = tx_data << 1;
            end else begin
                mosi_d = tx_data[0];
                sh_d   = tx_data >> 1;
            end
        end
        unique case (state_q)
            IDLE, STREAM_WAIT: begin
                if (accept) begin
                    state_d = SHIFT_LO;
                    cnt_d   = 8'd0;
                    bit_d   = '0;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    cnt_d = 8'd0;
                    if (bit_q == BIT_END) begin
                        bit_d = '0;
                        if (accept) begin
                            state_d = SHIFT_LO;
                        end else if (last_q) begin
                            state_d = CS_HOLD;
                        end else begin
                            state_d = STREAM_WAIT;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                        if (MSB_FIRST) begin
                            mosi_d = sh_q[W-1];
                            sh_d   = sh_q << 1;
                        end else begin
                            mosi_d = sh_q[0];
                            sh_d   = sh_q >> 1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CS_HOLD: begin
                if (phase_end) begin
                    state_d = CS_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CS_IDLE: begin
                if (phase_end) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                bit_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= '0;
            sh_q    <= '0;
            mosi_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            mosi_q  <= mosi_d;
            last_q  <= last_d;
        end
    end

    assign tx_ready      = ready;
    assign busy          = (state_q != IDLE);
    assign spi_clk       = (state_q == SHIFT_HI);
    assign MOSI          = mosi_q;
    assign chip_select_n = !((state_q == SHIFT_LO) || (state_q == SHIFT_HI) ||
                             (state_q == STREAM_WAIT) || (state_q == CS_HOLD));

`ifdef SPI_STREAM_MISO_CAPTURE_EN
    logic [W-1:0] rx_sh_q, rx_sh_d;
    logic [W-1:0] rx_data_q;
    logic         rx_valid_q;
    logic [W-1:0] miso_vec;

    // MISO shifts in on the first SHIFT_HI cycle, same order as MOSI.
    always_comb begin
        rx_sh_d  = rx_sh_q;
        miso_vec = '0;
        if ((state_q == SHIFT_HI) && (cnt_q == 8'd0)) begin
            if (MSB_FIRST) begin
                miso_vec[0] = MISO;
                rx_sh_d     = (rx_sh_q << 1) | miso_vec;
            end else begin
                miso_vec[W-1] = MISO;
                rx_sh_d       = (rx_sh_q >> 1) | miso_vec;
            end
        end
    end

    // Publish the captured word the cycle after its last SHIFT_HI.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= word_end;
            if (word_end) begin
                rx_data_q <= rx_sh_d;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_miso;

    assign unused_miso = MISO;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_stream_master.sv
// Bench for spi_stream_master: two configurations, loopback MISO,
// bit-level reference model built from the transmitted words.
`timescale 1ns/1ps
module tb_spi_stream_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0]  tx_data_a, rx_data_a;
    logic        tx_valid_a, tx_last_a, tx_ready_a, rx_valid_a;
    logic        busy_a, sclk_a, mosi_a, miso_a, csn_a;
    logic [15:0] tx_data_b, rx_data_b;
    logic        tx_valid_b, tx_last_b, tx_ready_b, rx_valid_b;
    logic        busy_b, sclk_b, mosi_b, miso_b, csn_b;

    assign miso_a = mosi_a;
    assign miso_b = mosi_b;

    spi_stream_master #(.WIDTH_SPI_WORD(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_last(tx_last_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .busy(busy_a), .spi_clk(sclk_a), .MOSI(mosi_a),
        .MISO(miso_a), .chip_select_n(csn_a)
    );

    spi_stream_master #(.WIDTH_SPI_WORD(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_last(tx_last_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .busy(busy_b), .spi_clk(sclk_b), .MOSI(mosi_b),
        .MISO(miso_b), .chip_select_n(csn_b)
    );

    int checks = 0;
    int passed = 0;

    // Observed bus activity, sampled mid-cycle
    logic        sp_a = 1'b0, cp_a = 1'b1, rvp_a = 1'b0;
    logic        sp_b = 1'b0, cp_b = 1'b1, rvp_b = 1'b0;
    int          cs_low_a = 0, cs_low_b = 0, hi_b = 0, dup = 0;
    logic        bits_a[$], bits_b[$];
    int          lens_a[$], lens_b[$];
    logic [7:0]  rxq_a[$];
    logic [15:0] rxq_b[$];

    // Reference model queues
    logic        exp_a[$], exp_b[$];
    logic [7:0]  wexp_a[$];
    logic [15:0] wexp_b[$];

    always @(negedge clk) begin
        sp_a  <= sclk_a;
        cp_a  <= csn_a;
        rvp_a <= rx_valid_a;
        if (sclk_a === 1'b1 && sp_a === 1'b0) bits_a.push_back(mosi_a);
        if (csn_a === 1'b0) cs_low_a <= cs_low_a + 1;
        if (csn_a === 1'b1 && cp_a === 1'b0) begin
            lens_a.push_back(cs_low_a);
            cs_low_a <= 0;
        end
        if (rx_valid_a === 1'b1) begin
            rxq_a.push_back(rx_data_a);
            if (rvp_a === 1'b1) dup <= dup + 1;
        end
    end

    always @(negedge clk) begin
        sp_b  <= sclk_b;
        cp_b  <= csn_b;
        rvp_b <= rx_valid_b;
        if (sclk_b === 1'b1 && sp_b === 1'b0) bits_b.push_back(mosi_b);
        if (sclk_b === 1'b1) hi_b <= hi_b + 1;
        if (csn_b === 1'b0) cs_low_b <= cs_low_b + 1;
        if (csn_b === 1'b1 && cp_b === 1'b0) begin
            lens_b.push_back(cs_low_b);
            cs_low_b <= 0;
        end
        if (rx_valid_b === 1'b1) begin
            rxq_b.push_back(rx_data_b);
            if (rvp_b === 1'b1) dup <= dup + 1;
        end
    end

    function automatic void model_a(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_a.push_back(w[i]);
        wexp_a.push_back(w);
    endfunction

    function automatic void model_b(input logic [15:0] w);
        for (int i = 0; i < 16; i++) exp_b.push_back(w[i]);
        wexp_b.push_back(w);
    endfunction

    function automatic int diff_a();
        if (bits_a.size() != exp_a.size()) return -2;
        foreach (exp_a[i]) if (bits_a[i] !== exp_a[i]) return i;
        return -1;
    endfunction

    function automatic int diff_b();
        if (bits_b.size() != exp_b.size()) return -2;
        foreach (exp_b[i]) if (bits_b[i] !== exp_b[i]) return i;
        return -1;
    endfunction

    function automatic int rxdiff_a();
        if (rxq_a.size() != wexp_a.size()) return -2;
        foreach (wexp_a[i]) if (rxq_a[i] !== wexp_a[i]) return i;
        return -1;
    endfunction

    function automatic void clear_all();
        bits_a.delete(); bits_b.delete(); lens_a.delete(); lens_b.delete();
        rxq_a.delete(); rxq_b.delete(); exp_a.delete(); exp_b.delete();
        wexp_a.delete(); wexp_b.delete();
    endfunction

    task automatic push_a(input logic [7:0] d, input logic l);
        int n = 0;
        tx_data_a = d; tx_last_a = l; tx_valid_a = 1'b1;
        while (tx_ready_a !== 1'b1 && n < 2000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 2000) $display("FAIL push_a_timeout ready=%b required 1", tx_ready_a);
        else passed++;
        @(negedge clk);
        tx_data_a = 8'($urandom);
    endtask

    task automatic push_b(input logic [15:0] d, input logic l);
        int n = 0;
        tx_data_b = d; tx_last_b = l; tx_valid_b = 1'b1;
        while (tx_ready_b !== 1'b1 && n < 2000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 2000) $display("FAIL push_b_timeout ready=%b required 1", tx_ready_b);
        else passed++;
        @(negedge clk);
        tx_data_b = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a !== 1'b0 || busy_b !== 1'b0 || tx_ready_a !== 1'b1) && n < 5000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 5000) $display("FAIL idle_timeout busy=%b%b required 00", busy_a, busy_b);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({csn_a, sclk_a, mosi_a, tx_ready_a, busy_a, rx_valid_a} !== 6'b100000 ||
            rx_data_a !== 8'h00)
            $display("FAIL reset_a got=%b/%h required 100000/00",
                     {csn_a, sclk_a, mosi_a, tx_ready_a, busy_a, rx_valid_a}, rx_data_a);
        else passed++;
        checks++;
        if ({csn_b, sclk_b, mosi_b, tx_ready_b, busy_b, rx_valid_b} !== 6'b100000 ||
            rx_data_b !== 16'h0)
            $display("FAIL reset_b got=%b/%h required 100000/0000",
                     {csn_b, sclk_b, mosi_b, tx_ready_b, busy_b, rx_valid_b}, rx_data_b);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready_a !== 1'b1 || tx_ready_b !== 1'b1)
            $display("FAIL ready_after_reset got=%b%b required 11", tx_ready_a, tx_ready_b);
        else passed++;
    endtask

    task automatic test_single_a5();
        int n = 0;
        int d;
        clear_all();
        model_a(8'hA5);
        push_a(8'hA5, 1'b1);
        tx_valid_a = 1'b0;
        while (csn_a === 1'b0 && n < 200) begin
            @(negedge clk); n++;
        end
        n = 0;
        while (tx_ready_a !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n !== 2) $display("FAIL a5_ready_gap got=%0d required 2", n);
        else passed++;
        wait_idle();
        d = diff_a();
        checks++;
        if (d != -1) $display("FAIL a5_bits diff_at=%0d got_n=%0d required_n=8", d, bits_a.size());
        else passed++;
        checks++;
        if (lens_a.size() != 1 || lens_a[0] != 34)
            $display("FAIL a5_cs_low frames=%0d len=%0d required 1/34",
                     lens_a.size(), lens_a.size() > 0 ? lens_a[0] : -1);
        else passed++;
`ifdef SPI_STREAM_MISO_CAPTURE_EN
        d = rxdiff_a();
`else
        d = (rxq_a.size() == 0 && rx_data_a === 8'h00) ? -1 : -3;
`endif
        checks++;
        if (d != -1) $display("FAIL a5_rx code=%0d got_n=%0d", d, rxq_a.size());
        else passed++;
    endtask

    task automatic test_stream();
        int d;
        clear_all();
        model_a(8'h3C);
        model_a(8'hC3);
        push_a(8'h3C, 1'b0);
        push_a(8'hC3, 1'b1);
        tx_valid_a = 1'b0;
        wait_idle();
        d = diff_a();
        checks++;
        if (d != -1) $display("FAIL stream_bits diff_at=%0d got_n=%0d required_n=16", d, bits_a.size());
        else passed++;
        checks++;
        if (lens_a.size() != 1 || lens_a[0] != 66)
            $display("FAIL stream_cs frames=%0d len=%0d required 1/66",
                     lens_a.size(), lens_a.size() > 0 ? lens_a[0] : -1);
        else passed++;
    endtask

    task automatic test_stream_wait();
        int n = 0;
        int d;
        logic ok = 1'b1;
        clear_all();
        model_a(8'h01);
        model_a(8'h80);
        push_a(8'h01, 1'b0);
        tx_valid_a = 1'b0;
        while (!(busy_a === 1'b1 && tx_ready_a === 1'b1 && sclk_a === 1'b0) && n < 200) begin
            @(negedge clk); n++;
        end
        for (int i = 0; i < 10; i++) begin
            if (csn_a !== 1'b0 || sclk_a !== 1'b0 || tx_ready_a !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok || n >= 200) $display("FAIL stream_wait got ok=%b wait=%0d required 1", ok, n);
        else passed++;
        push_a(8'h80, 1'b1);
        tx_valid_a = 1'b0;
        checks++;
        if ({mosi_a, sclk_a, csn_a} !== 3'b100)
            $display("FAIL resume_lo got=%b required 100", {mosi_a, sclk_a, csn_a});
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (sclk_a !== 1'b1) $display("FAIL resume_hi got=%b required 1", sclk_a);
        else passed++;
        wait_idle();
        d = diff_a();
        checks++;
        if (d != -1 || lens_a.size() != 1)
            $display("FAIL wait_bits diff_at=%0d frames=%0d required -1/1", d, lens_a.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_all();
        push_a(8'hFF, 1'b1);
        tx_valid_a = 1'b0;
        while (bits_a.size() < 4 && n < 200) begin
            @(negedge clk); n++;
        end
        while (sclk_a === 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({csn_a, sclk_a, mosi_a, tx_ready_a, busy_a, rx_valid_a} !== 6'b100000 || n >= 200)
            $display("FAIL reset_mid got=%b required 100000",
                     {csn_a, sclk_a, mosi_a, tx_ready_a, busy_a, rx_valid_a});
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready_a !== 1'b1 || rx_data_a !== 8'h00)
            $display("FAIL reset_mid_release got=%b/%h required 1/00", tx_ready_a, rx_data_a);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (rxq_a.size() != 0 || csn_a !== 1'b1)
            $display("FAIL reset_mid_rx got_n=%0d cs=%b required 0/1", rxq_a.size(), csn_a);
        else passed++;
    endtask

    task automatic test_random();
        int d;
        int frames = 0;
        logic [7:0] w;
        logic l;
        clear_all();
        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom);
            l = (i == 39) || ($urandom_range(0, 3) == 0);
            if (l) frames++;
            model_a(w);
            push_a(w, l);
            if ($urandom_range(0, 1) == 1) begin
                tx_valid_a = 1'b0;
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end
        tx_valid_a = 1'b0;
        wait_idle();
        d = diff_a();
        checks++;
        if (d != -1) $display("FAIL rand_bits diff_at=%0d got_n=%0d required_n=%0d", d, bits_a.size(), exp_a.size());
        else passed++;
        checks++;
        if (lens_a.size() != frames) $display("FAIL rand_frames got=%0d required %0d", lens_a.size(), frames);
        else passed++;
`ifdef SPI_STREAM_MISO_CAPTURE_EN
        d = rxdiff_a();
`else
        d = (rxq_a.size() == 0) ? -1 : -3;
`endif
        checks++;
        if (d != -1) $display("FAIL rand_rx code=%0d got_n=%0d", d, rxq_a.size());
        else passed++;
    endtask

    task automatic test_div1();
        int d;
        int h0;
        clear_all();
        h0 = hi_b;
        model_b(16'hBEEF);
        push_b(16'hBEEF, 1'b1);
        tx_valid_b = 1'b0;
        wait_idle();
        d = diff_b();
        checks++;
        if (d != -1) $display("FAIL div1_bits diff_at=%0d got_n=%0d required_n=16", d, bits_b.size());
        else passed++;
        checks++;
        if (lens_b.size() != 1 || lens_b[0] != 33 || (hi_b - h0) != 16)
            $display("FAIL div1_timing frames=%0d len=%0d hi=%0d required 1/33/16",
                     lens_b.size(), lens_b.size() > 0 ? lens_b[0] : -1, hi_b - h0);
        else passed++;
        checks++;
`ifdef SPI_STREAM_MISO_CAPTURE_EN
        if (rxq_b.size() != 1 || rxq_b[0] !== 16'hBEEF)
            $display("FAIL div1_rx got_n=%0d required 1 word beef", rxq_b.size());
`else
        if (rxq_b.size() != 0 || rx_data_b !== 16'h0)
            $display("FAIL div1_rx got_n=%0d required 0", rxq_b.size());
`endif
        else passed++;
    endtask

    task automatic test_loopback_5a();
        clear_all();
        push_b(16'h005A, 1'b1);
        tx_valid_b = 1'b0;
        wait_idle();
        checks++;
`ifdef SPI_STREAM_MISO_CAPTURE_EN
        if (rxq_b.size() != 1 || rxq_b[0] !== 16'h005A || rx_data_b !== 16'h005A)
            $display("FAIL loop_5a got_n=%0d data=%h required 1/005a", rxq_b.size(), rx_data_b);
`else
        if (rxq_b.size() != 0 || rx_data_b !== 16'h0)
            $display("FAIL loop_5a got_n=%0d data=%h required 0/0000", rxq_b.size(), rx_data_b);
`endif
        else passed++;
        checks++;
        if (dup != 0) $display("FAIL rx_pulse_width got=%0d required 0", dup);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        tx_data_a = '0; tx_valid_a = 1'b0; tx_last_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; tx_last_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_stream();
        test_stream_wait();
        test_reset_mid();
        test_random();
        test_div1();
        test_loopback_5a();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
